// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data port B preferred, fetch port A protected from starvation.
// Define ARB_LOCK_EN to let B hold ownership across accesses via b_lock.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  output logic        a_gnt,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_lock,
  input  logic [3:0]  b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       locked;

  assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));

`ifdef ARB_LOCK_EN
  assign locked = (state == LOCKED);
`else
  logic unused_lock;
  assign unused_lock = b_lock;
  assign locked = 1'b0;
`endif

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (locked) begin
        b_gnt = b_req;
      end else if (a_req && b_req) begin
        a_gnt = starve_hit;
        b_gnt = !starve_hit;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  assign mem_en    = a_gnt | b_gnt;
  assign mem_we    = b_gnt ? b_we : 4'b0000;
  assign mem_wdata = b_gnt ? b_wdata : 32'h0;
  assign mem_addr  = b_gnt ? b_addr : (a_gnt ? a_addr : 32'h0);
  assign rdata     = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      a_rvalid <= a_gnt;
      b_rvalid <= b_gnt && (b_we == 4'b0000);
      // counter is frozen while B owns the memory
      if (!locked) begin
        if (a_gnt || !a_req)
          starve_cnt <= 4'd0;
        else if (b_gnt && !starve_hit)
          starve_cnt <= starve_cnt + 4'd1;
      end
`ifdef ARB_LOCK_EN
      unique case (state)
        ARB: begin
          if (b_gnt && b_lock)
            state <= LOCKED;
        end
        LOCKED: begin
          if ((b_gnt && !b_lock) || (!b_req && !b_lock))
            state <= ARB;
        end
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req;
  logic [31:0] a_addr;
  logic        a_gnt;
  logic        a_rvalid;
  logic        b_req;
  logic        b_lock;
  logic [3:0]  b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .a_req(a_req),
    .a_addr(a_addr),
    .a_gnt(a_gnt),
    .a_rvalid(a_rvalid),
    .b_req(b_req),
    .b_lock(b_lock),
    .b_we(b_we),
    .b_addr(b_addr),
    .b_wdata(b_wdata),
    .b_gnt(b_gnt),
    .b_rvalid(b_rvalid),
    .rdata(rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    @(negedge clk);
    a_req  = 1'b0;
    b_req  = 1'b0;
    b_lock = 1'b0;
    b_we   = 4'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    a_req = 1'b1;
    b_req = 1'b1;
    b_we  = 4'hF;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_en} !== 3'b000) begin
      bad++;
      $display("FAIL rst_gnt: got %b want 000", {a_gnt, b_gnt, mem_en});
    end
    total++;
    if (mem_we !== 4'h0) begin
      bad++;
      $display("FAIL rst_we: got %h want 0", mem_we);
    end
    @(negedge clk);
    #1;
    total++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL rst_rvalid: got %b want 00", {a_rvalid, b_rvalid});
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_a_only();
    logic g;
    logic v;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_req     = (k < 3);
      a_addr    = 32'h100;
      mem_rdata = 32'hA000_0000 + 32'(k);
      #1;
      g = (k < 3);
      v = (k >= 1 && k <= 3);
      total++;
      if (a_gnt !== g || b_gnt !== 1'b0 || mem_en !== g) begin
        bad++;
        $display("FAIL a_only_gnt[%0d]: got a=%b b=%b en=%b want a=%b b=0 en=%b",
                 k, a_gnt, b_gnt, mem_en, g, g);
      end
      if (g) begin
        total++;
        if (mem_addr !== 32'h100 || mem_we !== 4'h0 || mem_wdata !== 32'h0) begin
          bad++;
          $display("FAIL a_only_bus[%0d]: got addr=%h we=%h wd=%h want 100/0/0",
                   k, mem_addr, mem_we, mem_wdata);
        end
      end
      total++;
      if (a_rvalid !== v || b_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL a_only_rvalid[%0d]: got a=%b b=%b want a=%b b=0",
                 k, a_rvalid, b_rvalid, v);
      end
      total++;
      if (rdata !== 32'hA000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL a_only_rdata[%0d]: got %h want %h",
                 k, rdata, 32'hA000_0000 + 32'(k));
      end
    end
    idle();
  endtask

  task automatic test_starve();
    logic ea;
    a_addr = 32'h100;
    b_addr = 32'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_req = 1'b1;
      b_req = 1'b1;
      b_we  = 4'h0;
      #1;
      ea = ((i % 5) == 4);
      total++;
      if (a_gnt !== ea || b_gnt !== !ea) begin
        bad++;
        $display("FAIL starve[%0d]: got a=%b b=%b want a=%b b=%b",
                 i, a_gnt, b_gnt, ea, !ea);
      end
      total++;
      if (mem_addr !== (ea ? 32'h100 : 32'h200)) begin
        bad++;
        $display("FAIL starve_addr[%0d]: got %h want %h",
                 i, mem_addr, ea ? 32'h100 : 32'h200);
      end
    end
    idle();
  endtask

  task automatic test_write();
    @(negedge clk);
    b_req   = 1'b1;
    b_we    = 4'b0011;
    b_addr  = 32'h2004;
    b_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_en !== 1'b1) begin
      bad++;
      $display("FAIL wr_gnt: got a=%b b=%b en=%b want 0 1 1", a_gnt, b_gnt, mem_en);
    end
    total++;
    if (mem_we !== 4'b0011 || mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_bus: got we=%b addr=%h wd=%h want 0011/2004/deadbeef",
               mem_we, mem_addr, mem_wdata);
    end
    idle();
    #1;
    total++;
    if (b_rvalid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0) begin
      bad++;
      $display("FAIL wr_after: got rv=%b en=%b we=%h want 0 0 0", b_rvalid, mem_en, mem_we);
    end
  endtask

  task automatic test_reset_mid();
    logic ea;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_req = 1'b1;
      b_req = 1'b1;
      b_we  = 4'h0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_en, mem_we} !== 7'b0) begin
      bad++;
      $display("FAIL midrst_gnt: got a=%b b=%b en=%b we=%h want all 0",
               a_gnt, b_gnt, mem_en, mem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_rvalid: got a=%b b=%b want 0 0", a_rvalid, b_rvalid);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      ea = (i == 4);
      total++;
      if (a_gnt !== ea || b_gnt !== !ea) begin
        bad++;
        $display("FAIL midrst_seq[%0d]: got a=%b b=%b want a=%b b=%b",
                 i, a_gnt, b_gnt, ea, !ea);
      end
    end
    idle();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    a_req  = 1'b1;
    b_req  = 1'b1;
    b_lock = 1'b1;
    b_we   = 4'h0;
    #1;
    total++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lock_first: got a=%b b=%b want 0 1", a_gnt, b_gnt);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_req = 1'b0;
      #1;
      total++;
      if (a_gnt !== 1'b0 || mem_en !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold[%0d]: got a=%b en=%b want 0 0", i, a_gnt, mem_en);
      end
    end
    @(negedge clk);
    b_lock = 1'b0;
    #1;
    total++;
    if (a_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lock_release: got a=%b want 0", a_gnt);
    end
    @(negedge clk);
    #1;
    total++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lock_after: got a=%b b=%b want 1 0", a_gnt, b_gnt);
    end
    idle();
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    a_req     = 1'b0;
    a_addr    = 32'h0;
    b_req     = 1'b0;
    b_lock    = 1'b0;
    b_we      = 4'h0;
    b_addr    = 32'h0;
    b_wdata   = 32'h0;
    mem_rdata = 32'h0;
    test_reset();
    test_a_only();
    test_starve();
    test_write();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
